// File: rtl/alu_exec.sv
// Execute-stage ALU. Single-cycle ops register their result on the accepting
// edge. Signed mult/div iterate one bit per edge into HI/LO while issue stalls.
//
// Handshake: an operation is accepted on a rising edge where in_valid and
// in_ready are both high. in_ready is high only in IDLE. out_valid is a
// one-cycle pulse. result/zero/overflow/hi/lo hold their values until the next
// completion, so the consumer must sample them during the pulse.
module alu_exec #(
  parameter int WIDTH = 32,
  parameter bit MD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             neg_res;   // quotient/product sign flips
  logic             a_neg;     // remainder takes the sign of a
  logic             b_zero;
  logic [WIDTH-1:0] acc;       // mult: product high word / div: partial remainder
  logic [WIDTH-1:0] q;         // mult: multiplier -> product low / div: dividend -> quotient
  logic [WIDTH-1:0] m;         // mult: |multiplicand| / div: |divisor|

  logic             md_op;
  logic             accept;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [WIDTH-1:0] add_res, sub_res;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh, div_diff;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] quo_s, rem_s;
  logic [WIDTH-1:0] fin_hi, fin_lo;

  assign md_op  = MD_EN && (ctr == 4'b1100 || ctr == 4'b1101);
  assign accept = in_valid && in_ready;
  assign a_abs  = a[WIDTH-1] ? -a : a;
  assign b_abs  = b[WIDTH-1] ? -b : b;
  assign add_res = a + b;
  assign sub_res = a - b;

  // Single-cycle result and signed overflow for the presented code.
  always_comb begin
    alu_res = add_res;
    alu_ovf = 1'b0;
    case (ctr)
      4'b0000: alu_res = a & b;
      4'b0001: alu_res = a | b;
      4'b0100: alu_res = a ^ b;
      4'b0101: alu_res = ~(a | b);
      4'b0110: begin
        alu_res = sub_res;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b1000: alu_res = b << shamt;
      4'b1001: alu_res = b >> shamt;
      4'b1010: alu_res = $signed(b) >>> shamt;
      4'b1011: alu_res = b << 16;
      default: begin
        // add, plus unused codes and mult/div when disabled
        alu_res = add_res;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
      end
    endcase
  end

  // One shift-add multiply step and one restoring divide step.
  always_comb begin
    mul_sum  = {1'b0, acc} + {1'b0, (q[0] ? m : {WIDTH{1'b0}})};
    div_sh   = {acc, q[WIDTH-1]};
    div_diff = div_sh - {1'b0, m};
  end

  // Sign correction and divide-by-zero override applied at completion.
  always_comb begin
    prod_s = neg_res ? -{acc, q} : {acc, q};
    quo_s  = b_zero ? {WIDTH{1'b1}} : (neg_res ? -q : q);
    rem_s  = a_neg ? -acc : acc;
    if (is_div) begin
      fin_hi = rem_s;
      fin_lo = quo_s;
    end else begin
      fin_hi = prod_s[2*WIDTH-1:WIDTH];
      fin_lo = prod_s[WIDTH-1:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: start on an accepted mult/div, return after the final edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && md_op) state_d = BUSY;
      BUSY:    if (cnt == CNT_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_ready = (state_q == IDLE);
  end

  // Datapath: single-cycle writeback, mult/div iterations and completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
      is_div    <= 1'b0;
      neg_res   <= 1'b0;
      a_neg     <= 1'b0;
      b_zero    <= 1'b0;
      acc       <= '0;
      q         <= '0;
      m         <= '0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        if (md_op) begin
          is_div  <= ctr[0];
          neg_res <= a[WIDTH-1] ^ b[WIDTH-1];
          a_neg   <= a[WIDTH-1];
          b_zero  <= (b == '0);
          cnt     <= '0;
          acc     <= '0;
          q       <= ctr[0] ? a_abs : b_abs;
          m       <= ctr[0] ? b_abs : a_abs;
        end else begin
          result    <= alu_res;
          zero      <= (alu_res == '0);
          overflow  <= alu_ovf;
          out_valid <= 1'b1;
        end
      end else if (state_q == BUSY) begin
        if (cnt != CNT_LAST) begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            if (!div_diff[WIDTH]) begin
              acc <= div_diff[WIDTH-1:0];
              q   <= {q[WIDTH-2:0], 1'b1};
            end else begin
              acc <= div_sh[WIDTH-1:0];
              q   <= {q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc <= mul_sum[WIDTH:1];
            q   <= {mul_sum[0], q[WIDTH-1:1]};
          end
        end else begin
          hi        <= fin_hi;
          lo        <= fin_lo;
          result    <= fin_lo;
          zero      <= (fin_lo == '0);
          overflow  <= 1'b0;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: one MD_EN=1 instance for the main function and
// one MD_EN=0 instance for the disabled mult/div path.
module tb_alu_exec;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_valid0 = 1'b0;
  logic [3:0]   ctr = 4'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [4:0]   shamt = 5'd0;

  logic         in_ready, out_valid, zero, overflow;
  logic [W-1:0] result, hi, lo;
  logic         in_ready0, out_valid0, zero0, overflow0;
  logic [W-1:0] result0, hi0, lo0;

  int tests = 0;
  int fails = 0;

  alu_exec #(.WIDTH(W), .MD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ctr(ctr), .a(a), .b(b), .shamt(shamt),
    .out_valid(out_valid), .result(result), .zero(zero), .overflow(overflow),
    .hi(hi), .lo(lo)
  );

  alu_exec #(.WIDTH(W), .MD_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .ctr(ctr), .a(a), .b(b), .shamt(shamt),
    .out_valid(out_valid0), .result(result0), .zero(zero0), .overflow(overflow0),
    .hi(hi0), .lo(lo0)
  );

  // clock
  always #5 clk = ~clk;

  // Present one op at a negedge; return at the negedge after the accepting edge.
  task automatic issue(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [4:0] s);
    @(negedge clk);
    in_valid = 1'b1; ctr = c; a = x; b = y; shamt = s;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Start a mult/div and wait for completion, poking in_valid while busy.
  task automatic run_md(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int busy, output bit done);
    issue(c, x, y, 5'd0);
    busy = 0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (out_valid) begin
        done = 1'b1;
      end else begin
        if (!in_ready) busy++;
        in_valid = (i >= 3 && i < 8);
        ctr = 4'b0010; a = 32'd1; b = 32'd1;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests++; if (result !== 32'h0) begin fails++; $display("FAIL reset_result: got %h expected 0", result); end
    tests++; if ({zero, overflow} !== 2'b00) begin fails++; $display("FAIL reset_flags: got %b expected 00", {zero, overflow}); end
    tests++; if ({hi, lo} !== 64'h0) begin fails++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo}); end
  endtask

  task automatic test_add_overflow;
    issue(4'b0010, 32'h7FFFFFFF, 32'h1, 5'd0);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL add_valid: got %b expected 1", out_valid); end
    tests++; if (result !== 32'h80000000) begin fails++; $display("FAIL add_result: got %h expected 80000000", result); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL add_overflow: got %b expected 1", overflow); end
    tests++; if (zero !== 1'b0) begin fails++; $display("FAIL add_zero: got %b expected 0", zero); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL add_pulse: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    in_valid = 1'b1; ctr = 4'b0110; a = 32'd5; b = 32'd5; shamt = 5'd0;
    @(negedge clk);
    tests++; if ({out_valid, in_ready, zero, overflow} !== 4'b1110 || result !== 32'h0)
      begin fails++; $display("FAIL b2b_sub: got v/r/z/o=%b result=%h expected 1110 0", {out_valid, in_ready, zero, overflow}, result); end
    ctr = 4'b0111; a = 32'hFFFFFFFF; b = 32'd1;
    @(negedge clk);
    tests++; if ({out_valid, in_ready, zero} !== 3'b110 || result !== 32'h1)
      begin fails++; $display("FAIL b2b_slt: got v/r/z=%b result=%h expected 110 1", {out_valid, in_ready, zero}, result); end
    ctr = 4'b1010; a = 32'h0; b = 32'h80000000; shamt = 5'd4;
    @(negedge clk);
    in_valid = 1'b0;
    tests++; if ({out_valid, in_ready} !== 2'b11 || result !== 32'hF8000000)
      begin fails++; $display("FAIL b2b_sra: got v/r=%b result=%h expected 11 f8000000", {out_valid, in_ready}, result); end
  endtask

  task automatic test_mult;
    int busy; bit done;
    run_md(4'b1100, 32'hFFFFFFFD, 32'd7, busy, done);
    tests++; if (!done) begin fails++; $display("FAIL mult_timeout: got no out_valid expected completion"); end
    tests++; if (busy != 33) begin fails++; $display("FAIL mult_busy_cycles: got %0d expected 33", busy); end
    tests++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB)
      begin fails++; $display("FAIL mult_hilo: got %h_%h expected ffffffff_ffffffeb", hi, lo); end
    tests++; if (result !== 32'hFFFFFFEB || zero !== 1'b0 || overflow !== 1'b0)
      begin fails++; $display("FAIL mult_result: got %h z=%b o=%b expected ffffffeb 0 0", result, zero, overflow); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b0 || result !== 32'hFFFFFFEB)
      begin fails++; $display("FAIL mult_hold: got v=%b result=%h expected 0 ffffffeb", out_valid, result); end
  endtask

  task automatic test_hilo_hold;
    issue(4'b0010, 32'd1, 32'd2, 5'd0);
    tests++; if (result !== 32'd3) begin fails++; $display("FAIL hold_add: got %h expected 3", result); end
    tests++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB)
      begin fails++; $display("FAIL hold_hilo: got %h_%h expected ffffffff_ffffffeb", hi, lo); end
  endtask

  task automatic test_div;
    int busy; bit done;
    run_md(4'b1101, 32'hFFFFFFF9, 32'd2, busy, done);
    tests++; if (!done || busy != 33) begin fails++; $display("FAIL div_latency: got done=%b busy=%0d expected 1 33", done, busy); end
    tests++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF)
      begin fails++; $display("FAIL div_hilo: got %h_%h expected ffffffff_fffffffd", hi, lo); end
    run_md(4'b1101, 32'd9, 32'd0, busy, done);
    tests++; if (!done || busy != 33) begin fails++; $display("FAIL div0_latency: got done=%b busy=%0d expected 1 33", done, busy); end
    tests++; if (lo !== 32'hFFFFFFFF || hi !== 32'd9)
      begin fails++; $display("FAIL div0_hilo: got %h_%h expected 00000009_ffffffff", hi, lo); end
    run_md(4'b1101, 32'h80000000, 32'hFFFFFFFF, busy, done);
    tests++; if (!done || lo !== 32'h80000000 || hi !== 32'h0)
      begin fails++; $display("FAIL div_min_neg1: got done=%b %h_%h expected 1 00000000_80000000", done, hi, lo); end
    run_md(4'b1101, 32'd3, 32'd5, busy, done);
    tests++; if (!done || lo !== 32'h0 || hi !== 32'd3 || zero !== 1'b1)
      begin fails++; $display("FAIL div_small: got done=%b %h_%h z=%b expected 1 00000003_00000000 1", done, hi, lo, zero); end
  endtask

  task automatic test_reset_mid_div;
    int seen;
    issue(4'b1101, 32'd100, 32'd7, 5'd0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin fails++; $display("FAIL rstdiv_state: got ready=%b valid=%b expected 1 0", in_ready, out_valid); end
    tests++; if ({hi, lo} !== 64'h0 || result !== 32'h0)
      begin fails++; $display("FAIL rstdiv_regs: got %h_%h result=%h expected 0", hi, lo, result); end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL rstdiv_no_valid: got %0d pulses expected 0", seen); end
    issue(4'b1011, 32'h0, 32'h1234, 5'd0);
    tests++; if (out_valid !== 1'b1 || result !== 32'h12340000)
      begin fails++; $display("FAIL lui: got v=%b result=%h expected 1 12340000", out_valid, result); end
  endtask

  task automatic test_unused_code;
    issue(4'b1111, 32'd2, 32'd3, 5'd0);
    tests++; if (out_valid !== 1'b1 || result !== 32'd5)
      begin fails++; $display("FAIL code1111: got v=%b result=%h expected 1 5", out_valid, result); end
    issue(4'b0101, 32'h0F0F0000, 32'h000000F0, 5'd0);
    tests++; if (result !== 32'hF0F0FF0F) begin fails++; $display("FAIL nor: got %h expected f0f0ff0f", result); end
    issue(4'b1001, 32'h0, 32'h80000000, 5'd31);
    tests++; if (result !== 32'h1) begin fails++; $display("FAIL srl: got %h expected 1", result); end
  endtask

  task automatic test_md_disabled;
    @(negedge clk);
    in_valid0 = 1'b1; ctr = 4'b1100; a = 32'd2; b = 32'd3; shamt = 5'd0;
    @(negedge clk);
    in_valid0 = 1'b0;
    tests++; if (out_valid0 !== 1'b1 || result0 !== 32'd5 || in_ready0 !== 1'b1)
      begin fails++; $display("FAIL mden0_mult: got v=%b r=%b result=%h expected 1 1 5", out_valid0, in_ready0, result0); end
    tests++; if ({hi0, lo0} !== 64'h0) begin fails++; $display("FAIL mden0_hilo: got %h_%h expected 0", hi0, lo0); end
  endtask

  initial begin
    test_reset;
    test_add_overflow;
    test_back_to_back;
    test_mult;
    test_hilo_hold;
    test_div;
    test_reset_mid_div;
    test_unused_code;
    test_md_disabled;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execute-stage ALU that consumes the 4-bit ALUctr code produced by the ALU control decoder and performs the selected operation on two operands.
- Single-cycle ops return a registered result one cycle after acceptance.
- Signed multiply and divide (ALUctr codes 1100/1101) run iteratively over WIDTH cycles into HI/LO registers, stalling issue through a valid/ready handshake.

Parameters:
- WIDTH, 32, operand/result width; also the multiply/divide iteration count.
- MD_EN, 1, 1 enables mult/div; 0 makes codes 1100/1101 execute as add.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept an operation (state IDLE).
- ctr  in  4  ALUctr code.
- a  in  WIDTH  operand A (rs).
- b  in  WIDTH  operand B (rt/imm).
- shamt  in  5  shift amount for codes 1000/1001/1010.
- out_valid  out  1  one-cycle pulse; result/flags valid.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- overflow  out  1  signed overflow (add/sub only).
- hi  out  WIDTH  HI register (mult high word / div remainder).
- lo  out  WIDTH  LO register (mult low word / div quotient).

Behaviour:
- Reset (synchronous, active-high; highest priority, aborts any in-flight mult/div):
  - state=IDLE, in_ready=1.
  - out_valid=0, result=0, zero=0, overflow=0, hi=0, lo=0.
  - Iteration counter and partial registers cleared.
- Acceptance: in_valid && in_ready at a rising edge.
- Code map, all evaluated on a, b, shamt sampled at acceptance:
  - 0000 and; 0001 or; 0010 add; 0110 sub.
  - 0100 xor; 0101 nor.
  - 0111 slt: signed compare, result 1 or 0.
  - 1000 sll b<<shamt; 1001 srl b>>shamt logical; 1010 sra b>>>shamt arithmetic.
  - 1011 lui: b<<16.
  - 1100 mult (signed); 1101 div (signed).
  - 0011, 1110, 1111: treated as add.
- Single-cycle ops:
  - Accepted at edge N: result, zero, overflow registered at edge N; out_valid=1 for the cycle following edge N.
  - in_ready stays 1, so back-to-back issue gives one result per cycle.
  - hi/lo are unchanged.
- overflow:
  - add: operands have the same sign and the result sign differs.
  - sub: operand signs differ and the result sign differs from a.
  - 0 for all other codes.
  - The result is still written on overflow (no trap).
- Multiply/divide FSM, states IDLE -> BUSY -> IDLE:
  - Accepted at edge 0: capture |a|, |b| and sign info; state=BUSY, cnt=0; in_ready=0.
  - Edges 1..WIDTH: one iteration per edge, cnt increments.
    - mult: unsigned shift-add, one multiplier bit per edge, 2*WIDTH product.
    - div: restoring, one quotient bit per edge.
  - Edge WIDTH+1: apply sign correction and write hi/lo; result=lo; zero=(lo==0); overflow=0; out_valid pulse; state=IDLE; in_ready=1.
  - in_valid is ignored while BUSY.
- Sign rules:
  - mult: negate the 2*WIDTH product if a and b signs differ.
  - div: quotient negated if signs differ; remainder takes the sign of a.
- Divide boundary cases:
  - Divide by zero: same latency; lo=all ones, hi=a.
  - 0x80000000 / -1: lo=0x80000000, hi=0.
- Single-cycle results during BUSY: none, since issue is blocked; hi/lo only change at mult/div completion.
- out_valid pulse contract: outputs hold their last values after the pulse until the next completion. The consumer must sample during the pulse.
- MD_EN=0: codes 1100/1101 behave as add; the FSM never leaves IDLE.

Test Plan:
- Reset then add a=0x7FFFFFFF, b=1, ctr=0010 -> next cycle out_valid=1, result=0x80000000, overflow=1, zero=0.
- Back-to-back: sub 5-5 (0110), then slt a=0xFFFFFFFF, b=1 (0111), then sra b=0x80000000 shamt=4 (1010) on consecutive cycles:
  - results 0 (zero=1), 1, 0xF8000000 on three consecutive out_valid cycles.
  - in_ready stays 1 throughout.
- mult a=-3 (0xFFFFFFFD), b=7 ->
  - in_ready=0 for 33 cycles; out_valid at edge 33.
  - hi=0xFFFFFFFF, lo=0xFFFFFFEB, result=0xFFFFFFEB.
  - in_valid pulses asserted during BUSY are not accepted.
- div a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - div a=9, b=0 -> lo=0xFFFFFFFF, hi=9, same latency.
- Reset asserted at cycle 10 of a div -> next edge: state IDLE, in_ready=1, hi=lo=0, no out_valid.
  - A following lui b=0x1234 -> result=0x12340000.
- Unused code 1111 with a=2, b=3 -> result=5; MD_EN=0 build with ctr=1100, a=2, b=3 -> result=5 after one cycle.
